// File: rtl/convert_arb.sv
// convert_arb: round-robin scheduler sharing one registered fixed-point
// requantizer between N_CH sample streams.
//
// The granted sample is aligned from BIN_PT_IN to BIN_PT_OUT fractional bits.
// Narrowing is rounded half-up; widening is exact. The result is range-checked
// against N_BITS_OUT and presented on one valid/ready output, tagged with its
// source channel.
//
// Optional feature: define CONVERT_ARB_SAT_EN to clamp out-of-range results to
// the most positive/negative output code. Without it, out-of-range results
// keep their low N_BITS_OUT bits (wrap).
//
// Ports:
//   clk       in   sole clock, rising edge
//   rst       in   synchronous active-high reset
//   din       in   packed samples, channel k at [k*N_BITS_IN +: N_BITS_IN]
//   din_vld   in   per-channel sample valid
//   din_rdy   out  per-channel accept, one-hot or zero
//   dout      out  converted sample
//   dout_ch   out  source channel of dout
//   dout_vld  out  output valid
//   dout_rdy  in   downstream accept
//   dout_ovf  out  this sample overflowed the output range
//   sat_cnt   out  overflow events since reset, sticks at all-ones
module convert_arb #(
  parameter int N_CH       = 4,
  parameter int N_BITS_IN  = 8,
  parameter int BIN_PT_IN  = 7,
  parameter int N_BITS_OUT = 4,
  parameter int BIN_PT_OUT = 3,
  parameter int CW         = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CH*N_BITS_IN-1:0] din,
  input  logic [N_CH-1:0]           din_vld,
  output logic [N_CH-1:0]           din_rdy,
  output logic [N_BITS_OUT-1:0]     dout,
  output logic [$clog2(N_CH)-1:0]   dout_ch,
  output logic                      dout_vld,
  input  logic                      dout_rdy,
  output logic                      dout_ovf,
  output logic [CW-1:0]             sat_cnt
);

  localparam int CHW = $clog2(N_CH);
  localparam int D   = BIN_PT_IN - BIN_PT_OUT;
  // Wide enough for the largest left shift (-D <= N_BITS_OUT) plus the
  // rounding carry, so alignment itself can never overflow.
  localparam int AW  = N_BITS_IN + N_BITS_OUT + 2;

  localparam logic [CHW:0] NCH_W = (CHW+1)'(N_CH);
  localparam logic signed [AW-1:0] MAX_V =
    {{(AW-N_BITS_OUT+1){1'b0}}, {(N_BITS_OUT-1){1'b1}}};
  localparam logic signed [AW-1:0] MIN_V =
    {{(AW-N_BITS_OUT+1){1'b1}}, {(N_BITS_OUT-1){1'b0}}};

  typedef enum logic {EMPTY, FULL} state_t;

  state_t                  state_q, state_d;
  logic [CHW-1:0]          ptr_q, ptr_d;
  logic [N_BITS_OUT-1:0]   dout_q, dout_d;
  logic [CHW-1:0]          ch_q, ch_d;
  logic                    ovf_q, ovf_d;
  logic [CW-1:0]           sat_q, sat_d;

  logic                    ld;
  logic                    found;
  logic [CHW-1:0]          grant;
  logic [CHW:0]            idx;
  logic                    xfer;
  logic signed [N_BITS_IN-1:0] sample;
  logic signed [AW-1:0]    ext;
  logic signed [AW-1:0]    aligned;
  logic                    ovf;
  logic [N_BITS_OUT-1:0]   res;

  assign ld = (state_q == EMPTY) || dout_rdy;

  // First valid channel searching upward from ptr, wrapping modulo N_CH.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int i = 0; i < N_CH; i++) begin
      idx = {1'b0, ptr_q} + (CHW+1)'(i);
      if (idx >= NCH_W) idx = idx - NCH_W;
      if (!found && din_vld[idx[CHW-1:0]]) begin
        found = 1'b1;
        grant = idx[CHW-1:0];
      end
    end
  end

  // No transfer may be acknowledged while reset is asserted.
  assign xfer = found && ld && !rst;

  always_comb begin
    din_rdy = '0;
    if (xfer) din_rdy[grant] = 1'b1;
  end

  assign sample = din[int'(grant)*N_BITS_IN +: N_BITS_IN];
  assign ext    = {{(AW-N_BITS_IN){sample[N_BITS_IN-1]}}, sample};

  generate
    if (D > 0) begin : g_round
      localparam logic signed [AW-1:0] HALF = {{(AW-1){1'b0}}, 1'b1} << (D-1);
      assign aligned = (ext + HALF) >>> D;
    end else begin : g_shift
      assign aligned = ext <<< (-D);
    end
  endgenerate

  assign ovf = (aligned > MAX_V) || (aligned < MIN_V);

`ifdef CONVERT_ARB_SAT_EN
  assign res = !ovf ? aligned[N_BITS_OUT-1:0]
             : (aligned > MAX_V) ? MAX_V[N_BITS_OUT-1:0]
             : MIN_V[N_BITS_OUT-1:0];
`else
  assign res = aligned[N_BITS_OUT-1:0];
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    dout_d  = dout_q;
    ch_d    = ch_q;
    ovf_d   = ovf_q;
    sat_d   = sat_q;
    if (xfer) begin
      state_d = FULL;
      dout_d  = res;
      ch_d    = grant;
      ovf_d   = ovf;
      ptr_d   = (grant == CHW'(N_CH-1)) ? '0 : grant + CHW'(1);
      if (ovf && (sat_q != {CW{1'b1}})) sat_d = sat_q + CW'(1);
    end else if ((state_q == FULL) && dout_rdy) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      dout_q  <= '0;
      ch_q    <= '0;
      ovf_q   <= 1'b0;
      sat_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      dout_q  <= dout_d;
      ch_q    <= ch_d;
      ovf_q   <= ovf_d;
      sat_q   <= sat_d;
    end
  end

  assign dout     = dout_q;
  assign dout_ch  = ch_q;
  assign dout_vld = (state_q == FULL);
  assign dout_ovf = ovf_q;
  assign sat_cnt  = sat_q;

endmodule

// File: tb/tb_convert_arb.sv
// tb_convert_arb: self-checking bench for convert_arb with default parameters,
// plus a second instance with a 2-bit saturation counter.
module tb_convert_arb;

  localparam int N_CH = 4;
  localparam int NBI  = 8;
  localparam int BPI  = 7;
  localparam int NBO  = 4;
  localparam int BPO  = 3;
  localparam int CW   = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [N_CH*NBI-1:0] din;
  logic [N_CH-1:0]   din_vld;
  logic [N_CH-1:0]   din_rdy, din_rdy2;
  logic [NBO-1:0]    dout, dout2;
  logic [1:0]        dout_ch, dout_ch2;
  logic              dout_vld, dout_vld2;
  logic              dout_rdy;
  logic              dout_ovf, dout_ovf2;
  logic [CW-1:0]     sat_cnt;
  logic [1:0]        sat_cnt2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  convert_arb #(.N_CH(N_CH), .N_BITS_IN(NBI), .BIN_PT_IN(BPI),
                .N_BITS_OUT(NBO), .BIN_PT_OUT(BPO), .CW(CW)) dut (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .din_rdy(din_rdy),
    .dout(dout), .dout_ch(dout_ch), .dout_vld(dout_vld), .dout_rdy(dout_rdy),
    .dout_ovf(dout_ovf), .sat_cnt(sat_cnt));

  convert_arb #(.N_CH(N_CH), .N_BITS_IN(NBI), .BIN_PT_IN(BPI),
                .N_BITS_OUT(NBO), .BIN_PT_OUT(BPO), .CW(2)) dut2 (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .din_rdy(din_rdy2),
    .dout(dout2), .dout_ch(dout_ch2), .dout_vld(dout_vld2), .dout_rdy(dout_rdy),
    .dout_ovf(dout_ovf2), .sat_cnt(sat_cnt2));

  // Reference model state
  int            m_ptr;
  bit            m_vld;
  logic [NBO-1:0] m_dout;
  int            m_ch;
  bit            m_ovf;
  longint        m_sat;

  function automatic longint floordiv(input longint n, input longint d);
    longint q;
    q = n / d;
    if ((n % d) != 0 && n < 0) q = q - 1;
    return q;
  endfunction

  // Requantize from the arithmetic definition: value * 2^BPO, rounded half-up.
  function automatic void ref_convert(input logic [NBI-1:0] x,
                                      output logic [NBO-1:0] y, output bit ovf);
    longint v, a, maxv, minv, w;
    int d;
    v = longint'($signed(x));
    d = BPI - BPO;
    if (d <= 0) a = v * (longint'(1) << (-d));
    else        a = floordiv(2*v + (longint'(1) << d), longint'(1) << (d+1));
    maxv = (longint'(1) << (NBO-1)) - 1;
    minv = -(longint'(1) << (NBO-1));
    ovf = (a > maxv) || (a < minv);
    w = a;
`ifdef CONVERT_ARB_SAT_EN
    if (a > maxv) w = maxv;
    if (a < minv) w = minv;
`endif
    y = w[NBO-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    din_vld = '0;
    tick();
    rst = 1'b0;
    m_ptr = 0; m_vld = 0; m_dout = '0; m_ch = 0; m_ovf = 0; m_sat = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    din = {N_CH{8'h10}};
    din_vld = '1;
    dout_rdy = 1'b1;
    #1;
    total++; if (din_rdy !== '0) begin bad++; $display("[TB] FAIL reset_din_rdy got=%b exp=0", din_rdy); end
    tick();
    total++; if (dout !== '0)     begin bad++; $display("[TB] FAIL reset_dout got=%h exp=0", dout); end
    total++; if (dout_ch !== '0)  begin bad++; $display("[TB] FAIL reset_dout_ch got=%0d exp=0", dout_ch); end
    total++; if (dout_vld !== 0)  begin bad++; $display("[TB] FAIL reset_dout_vld got=%b exp=0", dout_vld); end
    total++; if (dout_ovf !== 0)  begin bad++; $display("[TB] FAIL reset_dout_ovf got=%b exp=0", dout_ovf); end
    total++; if (sat_cnt !== '0)  begin bad++; $display("[TB] FAIL reset_sat_cnt got=%0d exp=0", sat_cnt); end
    rst = 1'b0;
    din_vld = '0;
  endtask

  task automatic test_convert();
    logic [7:0] samp [5];
    logic [3:0] expd [5];
    bit         expo [5];
    samp = '{8'h10, 8'h18, 8'hF8, 8'hF4, 8'h7F};
`ifdef CONVERT_ARB_SAT_EN
    expd = '{4'h1, 4'h2, 4'h0, 4'hF, 4'h7};
`else
    expd = '{4'h1, 4'h2, 4'h0, 4'hF, 4'h8};
`endif
    expo = '{0, 0, 0, 0, 1};
    do_reset();
    dout_rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      din[7:0] = samp[k];
      din_vld = 4'b0001;
      tick();
      total++; if (dout_vld !== 1'b1) begin bad++; $display("[TB] FAIL conv_vld[%0d] got=%b exp=1", k, dout_vld); end
      total++; if (dout !== expd[k]) begin bad++; $display("[TB] FAIL conv_dout[%0d] din=%h got=%h exp=%h", k, samp[k], dout, expd[k]); end
      total++; if (dout_ovf !== expo[k]) begin bad++; $display("[TB] FAIL conv_ovf[%0d] got=%b exp=%b", k, dout_ovf, expo[k]); end
    end
    total++; if (sat_cnt !== 16'd1) begin bad++; $display("[TB] FAIL conv_sat_cnt got=%0d exp=1", sat_cnt); end
    din_vld = '0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [7:0]  data [N_CH];
    logic [3:0]  ey;
    bit          eo;
    do_reset();
    for (int c = 0; c < N_CH; c++) begin
      data[c] = 8'($urandom);
      din[c*NBI +: NBI] = data[c];
    end
    din_vld = '1;
    dout_rdy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      ref_convert(data[k % N_CH], ey, eo);
      total++; if (dout_vld !== 1'b1) begin bad++; $display("[TB] FAIL rr_vld[%0d] got=%b exp=1", k, dout_vld); end
      total++; if (dout_ch !== 2'(k % N_CH)) begin bad++; $display("[TB] FAIL rr_ch[%0d] got=%0d exp=%0d", k, dout_ch, k % N_CH); end
      total++; if (dout !== ey) begin bad++; $display("[TB] FAIL rr_dout[%0d] got=%h exp=%h", k, dout, ey); end
    end
    din_vld = '0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [3:0] held;
    do_reset();
    din = {8'h20, 8'h40, 8'hC0, 8'h10};
    din_vld = 4'b1010;
    dout_rdy = 1'b1;
    tick();
    total++; if (dout_ch !== 2'd1 || dout_vld !== 1'b1) begin bad++; $display("[TB] FAIL bp_first got ch=%0d vld=%b exp ch=1 vld=1", dout_ch, dout_vld); end
    held = dout;
    dout_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (din_rdy !== '0) begin bad++; $display("[TB] FAIL bp_din_rdy[%0d] got=%b exp=0", k, din_rdy); end
      tick();
      total++; if (dout_ch !== 2'd1 || dout !== held || dout_vld !== 1'b1) begin
        bad++; $display("[TB] FAIL bp_hold[%0d] got ch=%0d dout=%h vld=%b exp ch=1 dout=%h vld=1", k, dout_ch, dout, dout_vld, held);
      end
    end
    dout_rdy = 1'b1;
    #1;
    total++; if (din_rdy !== 4'b1000) begin bad++; $display("[TB] FAIL bp_release_rdy got=%b exp=1000", din_rdy); end
    tick();
    total++; if (dout_ch !== 2'd3) begin bad++; $display("[TB] FAIL bp_next_ch got=%0d exp=3", dout_ch); end
    tick();
    total++; if (dout_ch !== 2'd1) begin bad++; $display("[TB] FAIL bp_after_ch got=%0d exp=1", dout_ch); end
    din_vld = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    din = {8'h10, 8'h7F, 8'h00, 8'h00};
    din_vld = 4'b1100;
    dout_rdy = 1'b1;
    tick();
    total++; if (dout_ch !== 2'd2 || sat_cnt !== 16'd1) begin bad++; $display("[TB] FAIL rm_pre got ch=%0d sat=%0d exp ch=2 sat=1", dout_ch, sat_cnt); end
    dout_rdy = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    total++; if (din_rdy !== '0) begin bad++; $display("[TB] FAIL rm_rst_rdy got=%b exp=0", din_rdy); end
    tick();
    rst = 1'b0;
    total++; if (dout_vld !== 1'b0 || sat_cnt !== '0) begin bad++; $display("[TB] FAIL rm_cleared got vld=%b sat=%0d exp vld=0 sat=0", dout_vld, sat_cnt); end
    #1;
    total++; if (din_rdy !== 4'b0100) begin bad++; $display("[TB] FAIL rm_first_grant got=%b exp=0100", din_rdy); end
    tick();
    total++; if (dout_ch !== 2'd2 || dout_vld !== 1'b1) begin bad++; $display("[TB] FAIL rm_first_out got ch=%0d vld=%b exp ch=2 vld=1", dout_ch, dout_vld); end
    din_vld = '0;
    dout_rdy = 1'b1;
    tick();
  endtask

  task automatic test_sat_cnt();
    logic [1:0] exp2 [5];
    exp2 = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    din[7:0] = 8'h7F;
    din_vld = 4'b0001;
    dout_rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      total++; if (sat_cnt2 !== exp2[k]) begin bad++; $display("[TB] FAIL sat2[%0d] got=%0d exp=%0d", k, sat_cnt2, exp2[k]); end
      total++; if (sat_cnt !== 16'(k+1)) begin bad++; $display("[TB] FAIL sat16[%0d] got=%0d exp=%0d", k, sat_cnt, k+1); end
    end
    din_vld = '0;
    tick();
  endtask

  task automatic test_random();
    bit         pend_vld [N_CH];
    logic [7:0] pend_data [N_CH];
    bit         ld, found;
    int         g;
    logic [N_CH-1:0] exp_rdy;
    logic [3:0] ey;
    bit         eo;
    do_reset();
    for (int c = 0; c < N_CH; c++) begin pend_vld[c] = 0; pend_data[c] = '0; end
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int c = 0; c < N_CH; c++) begin
        if (!pend_vld[c] && $urandom_range(0, 2) != 0) begin
          pend_vld[c] = 1;
          pend_data[c] = 8'($urandom);
        end
        din[c*NBI +: NBI] = pend_data[c];
        din_vld[c] = pend_vld[c];
      end
      dout_rdy = ($urandom_range(0, 3) != 0);
      ld = !m_vld || dout_rdy;
      found = 0;
      g = 0;
      for (int k = 0; k < N_CH; k++) begin
        if (!found && pend_vld[(m_ptr + k) % N_CH]) begin
          found = 1;
          g = (m_ptr + k) % N_CH;
        end
      end
      exp_rdy = (found && ld) ? (N_CH'(1) << g) : '0;
      #1;
      total++; if (din_rdy !== exp_rdy) begin bad++; $display("[TB] FAIL rnd_din_rdy[%0d] got=%b exp=%b", cyc, din_rdy, exp_rdy); end
      tick();
      if (found && ld) begin
        ref_convert(pend_data[g], ey, eo);
        m_dout = ey; m_ovf = eo; m_ch = g; m_vld = 1;
        m_ptr = (g + 1) % N_CH;
        if (eo && m_sat < 65535) m_sat++;
        pend_vld[g] = 0;
      end else if (m_vld && dout_rdy) begin
        m_vld = 0;
      end
      total++; if (dout_vld !== m_vld) begin bad++; $display("[TB] FAIL rnd_vld[%0d] got=%b exp=%b", cyc, dout_vld, m_vld); end
      if (m_vld) begin
        total++;
        if (dout !== m_dout || dout_ch !== 2'(m_ch) || dout_ovf !== m_ovf) begin
          bad++; $display("[TB] FAIL rnd_out[%0d] got dout=%h ch=%0d ovf=%b exp dout=%h ch=%0d ovf=%b",
                          cyc, dout, dout_ch, dout_ovf, m_dout, m_ch, m_ovf);
        end
      end
      total++; if (sat_cnt !== 16'(m_sat)) begin bad++; $display("[TB] FAIL rnd_sat[%0d] got=%0d exp=%0d", cyc, sat_cnt, m_sat); end
    end
    din_vld = '0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    din = '0;
    din_vld = '0;
    dout_rdy = 1'b0;
    #1;
    test_reset();
    test_convert();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_sat_cnt();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
